// File: rtl/mmio_hub.sv
// -----------------------------------------------------------------------------
// mmio_hub
//
// Memory-mapped I/O hub between the processor data-memory port and the
// external data RAM, the controller GPIO pins and the VGA controller.
//
// I/O map (address[12] = 1, offset = address[11:0]):
//   0x000+p               debounced button state of player p (read-only)
//   0x040+p               press latch of player p (clear-on-read)
//   0x080                 gpioOutput register (R/W, low OUT_WIDTH bits)
//   0x0C0+p*VGA_WORDS+w   sprite shadow word (R/W), committed to pVGA at vsync
//   0x0FF                 frame counter (R, any write clears it)
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   address        13-bit dmem word address (bit 12 selects I/O)
//   data_in, wren  processor write data / write enable
//   data_out       read data, one cycle after the address (same as RAM)
//   ram_wren       write enable to external RAM (never asserted for I/O)
//   ram_q          external RAM read data
//   gpio           raw controller pins, player p at [p*BTN_WIDTH +: BTN_WIDTH]
//   vga_vs         VGA vsync, asynchronous to clock
//   gpioOutput     output register
//   pVGA           committed sprite words, player p word w at
//                  [(p*VGA_WORDS+w)*32 +: 32]
// -----------------------------------------------------------------------------
module mmio_hub #(
   parameter int NUM_PLAYERS     = 2,
   parameter int BTN_WIDTH       = 18,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int OUT_WIDTH       = 3,
   parameter int VGA_WORDS       = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [12:0]                           address,
   input  logic [31:0]                           data_in,
   input  logic                                  wren,
   output logic [31:0]                           data_out,
   output logic                                  ram_wren,
   input  logic [31:0]                           ram_q,
   input  logic [NUM_PLAYERS*BTN_WIDTH-1:0]      gpio,
   input  logic                                  vga_vs,
   output logic [OUT_WIDTH-1:0]                  gpioOutput,
   output logic [NUM_PLAYERS*VGA_WORDS*32-1:0]   pVGA
);

   localparam int GPIO_W    = NUM_PLAYERS * BTN_WIDTH;
   localparam int NUM_WORDS = NUM_PLAYERS * VGA_WORDS;
   // Counter only has to hold 0..DEBOUNCE_CYCLES-1: the flip happens on the
   // edge that would take it to DEBOUNCE_CYCLES.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Raw pin level that means "released"; synchronisers reset to it so that
   // no phantom press is seen while they refill after reset.
   localparam logic [GPIO_W-1:0] RELEASED_PINS = (ACTIVE_LOW != 0) ? '1 : '0;

   // ---------------------------------------------------------------- decode
   logic [11:0] offset;
   logic        io_sel;
   logic        io_wr;
   logic        io_rd;

   assign offset   = address[11:0];
   assign io_sel   = address[12];
   assign io_wr    = io_sel & wren;
   assign io_rd    = io_sel & ~wren;
   assign ram_wren = wren & ~address[12];

   // ---------------------------------------------------------------- state
   logic [GPIO_W-1:0]    gpio_s1_reg;
   logic [GPIO_W-1:0]    gpio_s2_reg;
   logic [GPIO_W-1:0]    sample;
   logic [GPIO_W-1:0]    stable_reg;
   logic [GPIO_W-1:0]    stable_next;
   logic [GPIO_W-1:0]    rise;
   logic [GPIO_W-1:0]    latch_reg;
   logic [GPIO_W-1:0]    clr_mask;
   logic [CNT_W-1:0]     cnt_reg  [GPIO_W];
   logic [CNT_W-1:0]     cnt_next [GPIO_W];

   logic                 vs_s1_reg;
   logic                 vs_s2_reg;
   logic                 vs_s3_reg;
   logic                 commit;

   logic [31:0]          shadow_reg [NUM_WORDS];
   logic [NUM_WORDS*32-1:0] shadow_flat;
   logic [31:0]          frame_reg;

   logic [31:0]          io_rdata;
   logic [31:0]          io_rdata_reg;
   logic                 io_sel_reg;

   // Pressed = 1 after optional inversion.
   assign sample = (ACTIVE_LOW != 0) ? ~gpio_s2_reg : gpio_s2_reg;

   // ---------------------------------------------------------------- debounce
   genvar gi;
   generate
      for (gi = 0; gi < GPIO_W; gi++) begin : g_debounce
         logic differ;
         logic hit;
         assign differ          = sample[gi] ^ stable_reg[gi];
         assign hit             = differ && (cnt_reg[gi] == CNT_MAX);
         assign cnt_next[gi]    = (differ && !hit) ? cnt_reg[gi] + CNT_W'(1) : '0;
         assign stable_next[gi] = stable_reg[gi] ^ hit;
         assign rise[gi]        = hit & ~stable_reg[gi];
      end

      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_shadow_flat
         assign shadow_flat[gi*32 +: 32] = shadow_reg[gi];
      end
   endgenerate

   // One-cycle commit pulse on the synchronised vsync rising edge.
   assign commit = vs_s2_reg & ~vs_s3_reg;

   // ---------------------------------------------------------------- read mux
   always_comb begin
      io_rdata = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (offset == 12'(p))
            io_rdata[BTN_WIDTH-1:0] = stable_reg[p*BTN_WIDTH +: BTN_WIDTH];
         if (offset == 12'(64 + p))
            io_rdata[BTN_WIDTH-1:0] = latch_reg[p*BTN_WIDTH +: BTN_WIDTH];
      end
      if (offset == 12'h080)
         io_rdata[OUT_WIDTH-1:0] = gpioOutput;
      for (int w = 0; w < NUM_WORDS; w++) begin
         if (offset == 12'(192 + w))
            io_rdata = shadow_reg[w];
      end
      // Frame counter overrides any sprite word that would alias 0x0FF.
      if (offset == 12'h0FF)
         io_rdata = frame_reg;
   end

   // A latch read clears the whole player field; presses detected in the same
   // cycle are ORed back in afterwards so they are not lost.
   always_comb begin
      clr_mask = '0;
      if (io_rd) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (offset == 12'(64 + p))
               clr_mask[p*BTN_WIDTH +: BTN_WIDTH] = '1;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gpio_s1_reg  <= RELEASED_PINS;
         gpio_s2_reg  <= RELEASED_PINS;
         stable_reg   <= '0;
         latch_reg    <= '0;
         for (int i = 0; i < GPIO_W; i++)
            cnt_reg[i] <= '0;
         vs_s1_reg    <= 1'b0;
         vs_s2_reg    <= 1'b0;
         vs_s3_reg    <= 1'b0;
         for (int w = 0; w < NUM_WORDS; w++)
            shadow_reg[w] <= '0;
         pVGA         <= '0;
         frame_reg    <= '0;
         gpioOutput   <= '0;
         // Selecting the (zero) I/O read path keeps data_out at 0 during
         // reset regardless of what the RAM returns.
         io_sel_reg   <= 1'b1;
         io_rdata_reg <= '0;
      end else begin
         gpio_s1_reg <= gpio;
         gpio_s2_reg <= gpio_s1_reg;
         for (int i = 0; i < GPIO_W; i++)
            cnt_reg[i] <= cnt_next[i];
         stable_reg  <= stable_next;
         latch_reg   <= (latch_reg & ~clr_mask) | rise;

         vs_s1_reg <= vga_vs;
         vs_s2_reg <= vs_s1_reg;
         vs_s3_reg <= vs_s2_reg;

         if (io_wr && offset == 12'h080)
            gpioOutput <= data_in[OUT_WIDTH-1:0];

         for (int w = 0; w < NUM_WORDS; w++) begin
            if (io_wr && offset == 12'(192 + w) && offset != 12'h0FF)
               shadow_reg[w] <= data_in;
         end

         // shadow_flat holds pre-write values, so a write in the commit
         // cycle is picked up at the following vsync.
         if (commit)
            pVGA <= shadow_flat;

         if (io_wr && offset == 12'h0FF)
            frame_reg <= '0;
         else if (commit)
            frame_reg <= frame_reg + 32'd1;

         io_sel_reg   <= io_sel;
         io_rdata_reg <= io_rdata;
      end
   end

   assign data_out = io_sel_reg ? io_rdata_reg : ram_q;

endmodule
